// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/func
// constants, datapath select codes and the per-class control helper.
package mctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef CTRL_MEM_WAIT_EN
        , ST_MWAIT = 3'd5
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUBU  = 6'd35;

    localparam logic [2:0] ALU_OR   = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_SLL  = 3'd5;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC4  = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    typedef enum logic [3:0] {
        IC_ADDU = 4'd0,
        IC_SUBU = 4'd1,
        IC_SLL  = 4'd2,
        IC_ORI  = 4'd3,
        IC_LUI  = 4'd4,
        IC_LW   = 4'd5,
        IC_SW   = 4'd6,
        IC_BEQ  = 4'd7,
        IC_J    = 4'd8,
        IC_JAL  = 4'd9,
        IC_JR   = 4'd10,
        IC_ILL  = 4'd15
    } iclass_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // Datapath selects that stay constant from EXEC through the end of an instruction.
    function automatic ctrl_t class_ctrl(input iclass_e cls);
        ctrl_t c;
        c = '{alu_op: ALU_OR, alu_src: 1'b0, ext_op: EXT_ZERO,
              reg_dst: RD_RT, mem_to_reg: M2R_ALU};
        case (cls)
            IC_ADDU: begin c.alu_op = ALU_ADD; c.reg_dst = RD_RD; end
            IC_SUBU: begin c.alu_op = ALU_SUB; c.reg_dst = RD_RD; end
            IC_SLL:  begin c.alu_op = ALU_SLL; c.reg_dst = RD_RD; end
            IC_ORI:  begin c.alu_op = ALU_OR;  c.alu_src = 1'b1; c.ext_op = EXT_ZERO; end
            IC_LUI:  begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.ext_op = EXT_LUI;  end
            IC_LW: begin
                c.alu_op     = ALU_ADD;
                c.alu_src    = 1'b1;
                c.ext_op     = EXT_SIGN;
                c.mem_to_reg = M2R_MEM;
            end
            IC_SW:   begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.ext_op = EXT_SIGN; end
            IC_BEQ:  begin c.alu_op = ALU_SUB; end
            IC_JAL:  begin c.reg_dst = RD_RA; c.mem_to_reg = M2R_PC4; end
            default: begin c.alu_op = ALU_OR; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction classifier: op/func to instruction class plus an
// illegal flag for every encoding the controller does not implement.
module mctrl_decode
    import mctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_e    cls,
    output logic       illegal
);

    // Map opcode (and func for R-type) onto the supported instruction classes.
    always_comb begin
        cls = IC_ILL;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: cls = IC_ADDU;
                    FN_SUBU: cls = IC_SUBU;
                    FN_SLL:  cls = IC_SLL;
                    FN_JR:   cls = IC_JR;
                    default: cls = IC_ILL;
                endcase
            end
            OP_ORI:  cls = IC_ORI;
            OP_LUI:  cls = IC_LUI;
            OP_LW:   cls = IC_LW;
            OP_SW:   cls = IC_SW;
            OP_BEQ:  cls = IC_BEQ;
            OP_J:    cls = IC_J;
            OP_JAL:  cls = IC_JAL;
            default: cls = IC_ILL;
        endcase
        illegal = (cls == IC_ILL);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with retired-instruction counter.
// Optional memory wait state (MWAIT, mem_ready port) enabled by CTRL_MEM_WAIT_EN.
module multi_cycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int RET_W   = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
`ifdef CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src,
    output logic [1:0]         ext_op,
    output logic               rwe,
    output logic               mwe,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               illegal,
    output logic [RET_W-1:0]   retired
);

    state_e             state_q, state_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    iclass_e            cls_s;
    logic               dec_illegal_s;
    ctrl_t              ctl_s;
    logic               ir_we_s, pc_we_s, rwe_s, mwe_s, done_s, illegal_s;
    logic               is_sw_s;
    state_e             mem_succ_s;

    mctrl_decode u_decode (
        .op      (op),
        .func    (func),
        .cls     (cls_s),
        .illegal (dec_illegal_s)
    );

    assign ctl_s      = class_ctrl(cls_s);
    assign is_sw_s    = (cls_s == IC_SW);
    assign mem_succ_s = (cls_s == IC_LW) ? ST_WB : ST_FETCH;

    // Next-state, raw enables and datapath selects for the current state.
    always_comb begin
        state_d    = state_q;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        rwe_s      = 1'b0;
        mwe_s      = 1'b0;
        done_s     = 1'b0;
        illegal_s  = 1'b0;
        pc_src     = PC_PLUS4;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_op     = ALUOP_W'(ALU_OR);
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;

        // Class selects are meaningful only once the instruction is decoded.
        if (state_q != ST_FETCH && state_q != ST_DECODE) begin
            reg_dst    = ctl_s.reg_dst;
            mem_to_reg = ctl_s.mem_to_reg;
            alu_op     = ALUOP_W'(ctl_s.alu_op);
            alu_src    = ctl_s.alu_src;
            ext_op     = ctl_s.ext_op;
        end else begin
            alu_op     = ALUOP_W'(ALU_OR);
        end

        case (state_q)
            ST_FETCH: begin
                ir_we_s = 1'b1;
                pc_we_s = 1'b1;
                pc_src  = PC_PLUS4;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                illegal_s = dec_illegal_s;
                state_d   = dec_illegal_s ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_s)
                    IC_ADDU, IC_SUBU, IC_SLL, IC_ORI, IC_LUI: state_d = ST_WB;
                    IC_LW, IC_SW: state_d = ST_MEM;
                    IC_BEQ: begin
                        pc_we_s = zero;
                        pc_src  = PC_BRANCH;
                        done_s  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    IC_J: begin
                        pc_we_s = 1'b1;
                        pc_src  = PC_JUMP;
                        done_s  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    IC_JAL: begin
                        pc_we_s = 1'b1;
                        pc_src  = PC_JUMP;
                        rwe_s   = 1'b1;
                        done_s  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    IC_JR: begin
                        pc_we_s = 1'b1;
                        pc_src  = PC_RS;
                        done_s  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
`ifdef CTRL_MEM_WAIT_EN
            ST_MEM, ST_MWAIT: begin
                mwe_s = is_sw_s;
                if (mem_ready) begin
                    state_d = mem_succ_s;
                    done_s  = is_sw_s;
                end else begin
                    state_d = ST_MWAIT;
                end
            end
`else
            ST_MEM: begin
                mwe_s   = is_sw_s;
                state_d = mem_succ_s;
                done_s  = is_sw_s;
            end
`endif
            ST_WB: begin
                rwe_s   = 1'b1;
                done_s  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        retired_d = done_s ? (retired_q + RET_W'(1)) : retired_q;
    end

    // Reset overrides every write enable and pulse while it is held.
    assign ir_we      = ir_we_s   & ~reset;
    assign pc_we      = pc_we_s   & ~reset;
    assign rwe        = rwe_s     & ~reset;
    assign mwe        = mwe_s     & ~reset;
    assign instr_done = done_s    & ~reset;
    assign illegal    = illegal_s & ~reset;
    assign state      = state_q;
    assign retired    = retired_q;

    // State register and retired counter; reset may land mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule
